// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the IF (instruction read) and MEM (data read/write)
// requesters; MEM has priority, a starvation counter guarantees IF progress.
module mem_port_arbiter #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemLatency  = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   im_req,
    input  logic [AddrWidth-1:0]   im_addr,
    output logic [DataWidth-1:0]   im_rdata,
    output logic                   im_valid,
    input  logic                   dm_req,
    input  logic                   dm_we,
    input  logic [DataWidth/8-1:0] dm_be,
    input  logic [AddrWidth-1:0]   dm_addr,
    input  logic [DataWidth-1:0]   dm_wdata,
    output logic [DataWidth-1:0]   dm_rdata,
    output logic                   dm_valid,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [DataWidth/8-1:0] mem_be,
    output logic [AddrWidth-1:0]   mem_addr,
    output logic [DataWidth-1:0]   mem_wdata,
    input  logic [DataWidth-1:0]   mem_rdata,
    output logic                   grant_dm,
    output logic                   stall_if,
    output logic                   stall_mem
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = (MemLatency > 1) ? $clog2(MemLatency) : 1;
    localparam int unsigned StvWidth = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CntWidth-1:0]   r_wait_cnt;
    logic [StvWidth-1:0]   r_starve_cnt;
    logic                  r_grant_dm;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [BeWidth-1:0]    r_mem_be;
    logic [AddrWidth-1:0]  r_mem_addr;
    logic [DataWidth-1:0]  r_mem_wdata;
    logic [DataWidth-1:0]  r_im_rdata;
    logic [DataWidth-1:0]  r_dm_rdata;
    logic                  r_im_valid;
    logic                  r_dm_valid;

    logic                  w_grant;
    logic                  w_pick_dm;
    logic                  w_done;
    logic                  w_starved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (im_req || dm_req) w_next_state = S_ACCESS;
            S_ACCESS: if (r_wait_cnt == '0) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // IF wins a contested arbitration only once MEM has beaten it StarveLimit times in a row.
    always_comb begin
        w_starved = (r_starve_cnt == StvWidth'(StarveLimit));
        w_grant   = (r_state == S_IDLE) && (im_req || dm_req);
        w_pick_dm = dm_req && !(im_req && w_starved);
        w_done    = (r_state == S_ACCESS) && (r_wait_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_grant_dm   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_im_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_im_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
        end else begin
            r_im_valid <= 1'b0;
            r_dm_valid <= 1'b0;

            if (w_grant) begin
                r_grant_dm <= w_pick_dm;
                r_mem_en   <= 1'b1;
                r_wait_cnt <= CntWidth'(MemLatency - 1);
                if (w_pick_dm) begin
                    r_mem_addr  <= dm_addr;
                    r_mem_we    <= dm_we;
                    r_mem_be    <= dm_be;
                    r_mem_wdata <= dm_wdata;
                    if (im_req && !w_starved) begin
                        r_starve_cnt <= r_starve_cnt + StvWidth'(1);
                    end
                end else begin
                    r_mem_addr   <= im_addr;
                    r_mem_we     <= 1'b0;
                    r_mem_be     <= '1;
                    r_mem_wdata  <= '0;
                    r_starve_cnt <= '0;
                end
            end

            if (r_state == S_ACCESS && !w_done) begin
                r_wait_cnt <= r_wait_cnt - CntWidth'(1);
            end

            // Capture uses the still-registered write flag, so writes return zero data.
            if (w_done) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                r_mem_be <= '0;
                if (r_grant_dm) begin
                    r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
                    r_dm_valid <= 1'b1;
                end else begin
                    r_im_rdata <= mem_rdata;
                    r_im_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_en    = r_mem_en;
        mem_we    = r_mem_we;
        mem_be    = r_mem_be;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        im_rdata  = r_im_rdata;
        dm_rdata  = r_dm_rdata;
        im_valid  = r_im_valid;
        dm_valid  = r_dm_valid;
        grant_dm  = r_grant_dm;
        stall_if  = im_req & ~r_im_valid;
        stall_mem = dm_req & ~r_dm_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and read data are queued at stimulus time
// and popped when the DUT starts an access or pulses a valid.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;
    logic          im_valid;
    logic          dm_req;
    logic          dm_we;
    logic [BW-1:0] dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_en;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          grant_dm;
    logic          stall_if;
    logic          stall_mem;

    mem_port_arbiter #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .MemLatency (2),
        .StarveLimit(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .im_valid (im_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .grant_dm (grant_dm),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    typedef struct {
        logic          dm;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } grant_t;

    grant_t        q_grant[$];
    logic [DW-1:0] q_im[$];
    logic [DW-1:0] q_dm[$];
    int            v_cyc[$];
    int            v_who[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] last_im = '0;
    logic          prev_en = 1'b0;
    grant_t        mon_g;
    logic [DW-1:0] mon_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one fixed word at 0x100, otherwise a pattern derived from the address.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    always_comb mem_rdata = mem_val(mem_addr);

    task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_grant(input logic dm, input logic [AW-1:0] a, input logic we,
                              input logic [BW-1:0] be, input logic [DW-1:0] wd);
        grant_t g;
        g.dm = dm; g.addr = a; g.we = we; g.be = be; g.wdata = wd;
        q_grant.push_back(g);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Collects the cycle index of each valid pulse; optionally drops a requester after its valid.
    task automatic wait_valids(input int n, input int budget, input bit drop);
        int cyc  = 0;
        int seen = 0;
        bit pend_im = 1'b0;
        bit pend_dm = 1'b0;
        v_cyc.delete();
        v_who.delete();
        forever begin
            @(negedge clk);
            if (im_valid) begin v_cyc.push_back(cyc); v_who.push_back(0); seen++; pend_im = drop; end
            if (dm_valid) begin v_cyc.push_back(cyc); v_who.push_back(1); seen++; pend_dm = drop; end
            if (seen >= n) break;
            if (cyc >= budget) begin
                tb_check("valid_timeout", seen, n);
                break;
            end
            @(posedge clk);
            #1;
            if (pend_im) im_req = 1'b0;
            if (pend_dm) dm_req = 1'b0;
            pend_im = 1'b0;
            pend_dm = 1'b0;
            cyc++;
        end
        @(posedge clk);
        #1;
        im_req = 1'b0;
        dm_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en && !prev_en) begin
                if (q_grant.size() == 0) begin
                    tb_check("grant_unexpected", 1, 0);
                end else begin
                    mon_g = q_grant.pop_front();
                    tb_check("grant_dm", grant_dm, mon_g.dm);
                    tb_check("mem_addr", mem_addr, mon_g.addr);
                    tb_check("mem_we", mem_we, mon_g.we);
                    tb_check("mem_be", mem_be, mon_g.be);
                    tb_check("mem_wdata", mem_wdata, mon_g.wdata);
                end
            end
            if (im_valid && dm_valid) tb_check("both_valid", 1, 0);
            if (im_valid) begin
                if (q_im.size() == 0) begin
                    tb_check("im_valid_unexpected", 1, 0);
                end else begin
                    mon_d = q_im.pop_front();
                    tb_check("im_rdata", im_rdata, mon_d);
                    last_im = mon_d;
                end
            end
            if (dm_valid) begin
                if (q_dm.size() == 0) begin
                    tb_check("dm_valid_unexpected", 1, 0);
                end else begin
                    mon_d = q_dm.pop_front();
                    tb_check("dm_rdata", dm_rdata, mon_d);
                end
            end
        end
        prev_en = mem_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        im_req   = 1'b1;
        dm_req   = 1'b1;
        im_addr  = 32'h100;
        dm_addr  = 32'h200;
        dm_we    = 1'b1;
        dm_be    = '1;
        dm_wdata = 32'h5555AAAA;

        // Reset held with both requests active: registered outputs stay zero.
        @(posedge clk);
        #1;
        @(negedge clk);
        tb_check("rst_mem_en", mem_en, 0);
        tb_check("rst_mem_we", mem_we, 0);
        tb_check("rst_mem_be", mem_be, 0);
        tb_check("rst_mem_addr", mem_addr, 0);
        tb_check("rst_mem_wdata", mem_wdata, 0);
        tb_check("rst_im_rdata", im_rdata, 0);
        tb_check("rst_dm_rdata", dm_rdata, 0);
        tb_check("rst_im_valid", im_valid, 0);
        tb_check("rst_dm_valid", dm_valid, 0);
        tb_check("rst_grant_dm", grant_dm, 0);
        @(posedge clk);
        #1;
        im_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tb_check("idle_mem_en", mem_en, 0);
        end
        @(posedge clk);
        #1;

        // Single IF read with cycle-exact latency and stall.
        push_grant(1'b0, 32'h100, 1'b0, 4'hF, '0);
        q_im.push_back(32'hDEADBEEF);
        im_addr = 32'h100;
        im_req  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tb_check("t2_stall_if", stall_if, (c < 3));
            tb_check("t2_mem_en", mem_en, (c == 1 || c == 2));
            tb_check("t2_stall_mem", stall_mem, 0);
            if (c == 1 || c == 2) tb_check("t2_mem_addr_hold", mem_addr, 32'h100);
            if (c == 3) begin
                tb_check("t2_im_valid", im_valid, 1);
                tb_check("t2_grant_dm", grant_dm, 0);
            end
            @(posedge clk);
            #1;
        end
        im_req = 1'b0;
        idle(2);

        // Contested: MEM first, IF in the following IDLE.
        im_addr  = 32'h104;
        dm_addr  = 32'h200;
        dm_we    = 1'b0;
        dm_be    = 4'hF;
        dm_wdata = 32'hCAFE0000;
        push_grant(1'b1, 32'h200, 1'b0, 4'hF, 32'hCAFE0000);
        push_grant(1'b0, 32'h104, 1'b0, 4'hF, '0);
        q_dm.push_back(mem_val(32'h200));
        q_im.push_back(mem_val(32'h104));
        im_req = 1'b1;
        dm_req = 1'b1;
        wait_valids(2, 30, 1'b1);
        tb_check("t3_count", v_cyc.size(), 2);
        if (v_cyc.size() == 2) begin
            tb_check("t3_first_who", v_who[0], 1);
            tb_check("t3_first_cyc", v_cyc[0], 3);
            tb_check("t3_second_who", v_who[1], 0);
            tb_check("t3_second_cyc", v_cyc[1], 7);
        end
        idle(2);

        // Starvation limit 2 with both held: MEM, MEM, IF, MEM, MEM, IF.
        im_addr = 32'h108;
        dm_addr = 32'h20C;
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 2) begin
                push_grant(1'b0, 32'h108, 1'b0, 4'hF, '0);
                q_im.push_back(mem_val(32'h108));
            end else begin
                push_grant(1'b1, 32'h20C, 1'b0, 4'hF, 32'hCAFE0000);
                q_dm.push_back(mem_val(32'h20C));
            end
        end
        im_req = 1'b1;
        dm_req = 1'b1;
        wait_valids(6, 60, 1'b0);
        tb_check("t4_count", v_cyc.size(), 6);
        if (v_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                tb_check("t4_who", v_who[i], (i % 3 == 2) ? 0 : 1);
                tb_check("t4_cyc", v_cyc[i], 3 + 4 * i);
            end
        end
        idle(2);

        // MEM write: payload only during ACCESS, zero read data in RESP, IF data untouched.
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h200;
        dm_wdata = 32'h1234;
        push_grant(1'b1, 32'h200, 1'b1, 4'b0011, 32'h1234);
        q_dm.push_back('0);
        dm_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tb_check("t5_stall_mem", stall_mem, (c < 3));
            if (c == 1 || c == 2) begin
                tb_check("t5_mem_we", mem_we, 1);
                tb_check("t5_mem_be", mem_be, 4'b0011);
                tb_check("t5_mem_wdata", mem_wdata, 32'h1234);
            end
            if (c == 3) begin
                tb_check("t5_dm_valid", dm_valid, 1);
                tb_check("t5_resp_mem_we", mem_we, 0);
                tb_check("t5_resp_mem_be", mem_be, 0);
                tb_check("t5_resp_mem_en", mem_en, 0);
                tb_check("t5_grant_dm", grant_dm, 1);
                tb_check("t5_im_rdata_kept", im_rdata, last_im);
            end
            @(posedge clk);
            #1;
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        idle(2);

        // Asynchronous reset in the first ACCESS cycle abandons the access.
        im_addr = 32'h300;
        push_grant(1'b0, 32'h300, 1'b0, 4'hF, '0);
        q_im.push_back(mem_val(32'h300));
        im_req = 1'b1;
        @(posedge clk);
        #1;
        tb_check("t6_mem_en_before", mem_en, 1);
        rst_n = 1'b0;
        #1;
        tb_check("t6_mem_en_async", mem_en, 0);
        tb_check("t6_mem_addr_async", mem_addr, 0);
        tb_check("t6_im_valid_async", im_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_valids(1, 20, 1'b1);
        tb_check("t6_count", v_cyc.size(), 1);
        if (v_cyc.size() == 1) tb_check("t6_regrant_cyc", v_cyc[0], 3);
        idle(2);

        tb_check("left_grant", q_grant.size(), 0);
        tb_check("left_im", q_im.size(), 0);
        tb_check("left_dm", q_dm.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
